// File: rtl/alu_muldiv_if.sv
// Handshake bus for alu_muldiv: operation request channel plus result channel.
interface alu_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res_lo;
  logic [WIDTH-1:0] res_hi;
  logic             co;
  logic             zero;
  logic             overflow;
  logic             dz;
  logic             illegal;

  // Requester side: drives operations, consumes results.
  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, res_lo, res_hi, co, zero, overflow, dz, illegal
  );

  // ALU side: accepts operations, produces results.
  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, res_lo, res_hi, co, zero, overflow, dz, illegal
  );
endinterface

// File: rtl/alu_muldiv.sv
// Integer ALU with single-cycle logic/arith/shift ops and iterative
// unsigned multiply (shift-add) and divide (restoring), one bit per cycle.
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_muldiv_if.slave bus
);
  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_NOR  = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_SLTU = 4'd8;
  localparam logic [3:0] OP_SLL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_MULU = 4'd11;
  localparam logic [3:0] OP_DIVU = 4'd12;

  localparam logic [WIDTH-1:0] ILLEGAL_PATTERN = {(WIDTH/8){8'hA5}};

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;      // mul: upper partial product; div: remainder
  logic [WIDTH-1:0] lo_q, lo_d;      // mul: multiplier/lower product; div: dividend/quotient
  logic [WIDTH-1:0] opnd_q, opnd_d;  // multiplicand or divisor
  logic             is_div_q, is_div_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic             co_q, co_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             dz_q, dz_d;
  logic             ill_q, ill_d;

  logic             accept;
  logic             is_sub;
  logic [WIDTH-1:0] b_adj;
  logic [WIDTH:0]   sum;
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_co;
  logic             alu_ovf;
  logic             alu_ill;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  assign bus.in_ready  = (state_q == S_IDLE) && rst_n;
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.res_lo    = res_lo_q;
  assign bus.res_hi    = res_hi_q;
  assign bus.co        = co_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = ovf_q;
  assign bus.dz        = dz_q;
  assign bus.illegal   = ill_q;

  assign accept = bus.in_valid && bus.in_ready;

  // Single-cycle datapath: shared adder for ADD/SUB, logic, compares, shifts.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
    is_sub  = (bus.op == OP_SUB);
    b_adj   = bus.b ^ {WIDTH{is_sub}};
    sum     = {1'b0, bus.a} + {1'b0, b_adj} + {{WIDTH{1'b0}}, is_sub};
    shamt   = bus.b[SW-1:0];
    alu_res = '0;
    alu_co  = 1'b0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (bus.op)
      OP_AND:  alu_res = bus.a & bus.b;
      OP_OR:   alu_res = bus.a | bus.b;
      OP_XOR:  alu_res = bus.a ^ bus.b;
      OP_NOR:  alu_res = ~(bus.a | bus.b);
      OP_ADD, OP_SUB: begin
        alu_res = sum[WIDTH-1:0];
        alu_co  = sum[WIDTH];
        alu_ovf = (bus.a[WIDTH-1] == b_adj[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      OP_SLL:  alu_res = bus.a << shamt;
      OP_SRL:  alu_res = bus.a >> shamt;
      OP_SRA:  alu_res = $signed(bus.a) >>> shamt;
      OP_MULU, OP_DIVU: alu_res = '0;
      default: begin
        alu_res = ILLEGAL_PATTERN;
        alu_ill = 1'b1;
      end
    endcase
  end

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    // The true difference fits in WIDTH bits whenever div_ge holds.
    div_diff  = div_shift[WIDTH-1:0] - opnd_q;
    if (is_div_q) begin
      step_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // FSM and next-state for operand, counter and result registers.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    co_d     = co_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    dz_d     = dz_q;
    ill_d    = ill_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bus.op == OP_MULU || bus.op == OP_DIVU) begin
            state_d  = S_BUSY;
            cnt_d    = CW'(WIDTH);
            hi_d     = '0;
            lo_d     = bus.a;
            opnd_d   = bus.b;
            is_div_d = (bus.op == OP_DIVU);
          end else begin
            state_d  = S_DONE;
            res_lo_d = alu_res;
            res_hi_d = '0;
            co_d     = alu_co;
            zero_d   = (alu_res == '0);
            ovf_d    = alu_ovf;
            dz_d     = 1'b0;
            ill_d    = alu_ill;
          end
        end
      end
      S_BUSY: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d  = S_DONE;
          res_lo_d = step_lo;
          res_hi_d = step_hi;
          co_d     = 1'b0;
          zero_d   = (step_lo == '0);
          ovf_d    = 1'b0;
          dz_d     = is_div_q && (opnd_q == '0);
          ill_d    = 1'b0;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset clearing everything.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together from pre-edge values.
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      co_q     <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      dz_q     <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      co_q     <= co_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      dz_q     <= dz_d;
      ill_q    <= ill_d;
    end
  end
endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv at WIDTH=32.
module tb_alu_muldiv;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  alu_muldiv_if #(.WIDTH(W)) bus ();

  alu_muldiv #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Issue one op from IDLE; lat = edges from the accept edge (counted as 1) until out_valid.
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input string name, output int lat);
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      lat++;
    end while (!bus.out_valid && lat < 200);
    n_tests++;
    if (!bus.out_valid) begin
      n_fail++;
      $display("FAIL %s timeout: out_valid=%0b after %0d cycles, required 1", name, bus.out_valid, lat);
    end
  endtask

  // Let a DONE result drain (out_ready=1) back to IDLE.
  task automatic drain();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = '0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.res_lo !== '0 || bus.res_hi !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: out_valid=%0b res_lo=%h res_hi=%h, required 0/0/0",
               bus.out_valid, bus.res_lo, bus.res_hi);
    end
    n_tests++;
    if ({bus.co, bus.zero, bus.overflow, bus.dz, bus.illegal} !== 5'b0 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: flags=%b in_ready=%0b, required 00000/0",
               {bus.co, bus.zero, bus.overflow, bus.dz, bus.illegal}, bus.in_ready);
    end
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: in_ready=%0b, required 1", bus.in_ready);
    end
  endtask

  task automatic test_add_sub_sra();
    int lat;
    do_op(4'd2, 32'h7FFF_FFFF, 32'd1, "add_ovf", lat);
    n_tests++;
    if (bus.res_lo !== 32'h8000_0000 || bus.overflow !== 1'b1 || bus.co !== 1'b0 ||
        bus.zero !== 1'b0 || lat !== 1) begin
      n_fail++;
      $display("FAIL add_ovf: res_lo=%h ovf=%0b co=%0b zero=%0b lat=%0d, required 80000000/1/0/0/1",
               bus.res_lo, bus.overflow, bus.co, bus.zero, lat);
    end
    drain();
    do_op(4'd6, 32'd5, 32'd5, "sub_eq", lat);
    n_tests++;
    if (bus.res_lo !== 32'h0 || bus.zero !== 1'b1 || bus.co !== 1'b1 || bus.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_eq: res_lo=%h zero=%0b co=%0b ovf=%0b, required 0/1/1/0",
               bus.res_lo, bus.zero, bus.co, bus.overflow);
    end
    drain();
    do_op(4'd10, 32'h8000_0000, 32'd4, "sra", lat);
    n_tests++;
    if (bus.res_lo !== 32'hF800_0000 || bus.res_hi !== 32'h0) begin
      n_fail++;
      $display("FAIL sra: res_lo=%h res_hi=%h, required f8000000/0", bus.res_lo, bus.res_hi);
    end
    drain();
  endtask

  task automatic test_single_cycle_table();
    logic [3:0]   t_op [10];
    logic [W-1:0] t_a  [10];
    logic [W-1:0] t_b  [10];
    logic [W-1:0] t_r  [10];
    logic         t_co [10];
    logic         t_ov [10];
    logic         t_z  [10];
    int lat;
    t_op[0] = 4'd0; t_a[0] = 32'hF0F0_1234; t_b[0] = 32'h0FF0_FF00; t_r[0] = 32'h00F0_1200; t_co[0] = 0; t_ov[0] = 0; t_z[0] = 0;
    t_op[1] = 4'd1; t_a[1] = 32'hF000_0001; t_b[1] = 32'h0000_0F00; t_r[1] = 32'hF000_0F01; t_co[1] = 0; t_ov[1] = 0; t_z[1] = 0;
    t_op[2] = 4'd3; t_a[2] = 32'hAAAA_5555; t_b[2] = 32'hFFFF_0000; t_r[2] = 32'h5555_5555; t_co[2] = 0; t_ov[2] = 0; t_z[2] = 0;
    t_op[3] = 4'd4; t_a[3] = 32'hFFFF_0000; t_b[3] = 32'h0000_FFFF; t_r[3] = 32'h0000_0000; t_co[3] = 0; t_ov[3] = 0; t_z[3] = 1;
    t_op[4] = 4'd5; t_a[4] = 32'h8000_0000; t_b[4] = 32'h0000_0024; t_r[4] = 32'h0800_0000; t_co[4] = 0; t_ov[4] = 0; t_z[4] = 0;
    t_op[5] = 4'd9; t_a[5] = 32'h0000_0003; t_b[5] = 32'h0000_001F; t_r[5] = 32'h8000_0000; t_co[5] = 0; t_ov[5] = 0; t_z[5] = 0;
    t_op[6] = 4'd7; t_a[6] = 32'hFFFF_FFFF; t_b[6] = 32'h0000_0001; t_r[6] = 32'h0000_0001; t_co[6] = 0; t_ov[6] = 0; t_z[6] = 0;
    t_op[7] = 4'd8; t_a[7] = 32'hFFFF_FFFF; t_b[7] = 32'h0000_0001; t_r[7] = 32'h0000_0000; t_co[7] = 0; t_ov[7] = 0; t_z[7] = 1;
    t_op[8] = 4'd6; t_a[8] = 32'h0000_0003; t_b[8] = 32'h0000_0005; t_r[8] = 32'hFFFF_FFFE; t_co[8] = 0; t_ov[8] = 0; t_z[8] = 0;
    t_op[9] = 4'd6; t_a[9] = 32'h8000_0000; t_b[9] = 32'h0000_0001; t_r[9] = 32'h7FFF_FFFF; t_co[9] = 1; t_ov[9] = 1; t_z[9] = 0;
    for (int i = 0; i < 10; i++) begin
      do_op(t_op[i], t_a[i], t_b[i], "table", lat);
      n_tests++;
      if (bus.res_lo !== t_r[i] || bus.res_hi !== '0 || bus.co !== t_co[i] || bus.overflow !== t_ov[i] ||
          bus.zero !== t_z[i] || bus.dz !== 1'b0 || bus.illegal !== 1'b0 || lat !== 1) begin
        n_fail++;
        $display("FAIL table[%0d] op=%0d: res_lo=%h res_hi=%h co=%0b ovf=%0b zero=%0b dz=%0b ill=%0b lat=%0d, required %h/0/%0b/%0b/%0b/0/0/1",
                 i, t_op[i], bus.res_lo, bus.res_hi, bus.co, bus.overflow, bus.zero, bus.dz, bus.illegal, lat,
                 t_r[i], t_co[i], t_ov[i], t_z[i]);
      end
      drain();
    end
  endtask

  task automatic test_mulu();
    int lat;
    do_op(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulu_max", lat);
    n_tests++;
    if (bus.res_hi !== 32'hFFFF_FFFE || bus.res_lo !== 32'h0000_0001 || lat !== 33 || bus.zero !== 1'b0) begin
      n_fail++;
      $display("FAIL mulu_max: res_hi=%h res_lo=%h lat=%0d zero=%0b, required fffffffe/00000001/33/0",
               bus.res_hi, bus.res_lo, lat, bus.zero);
    end
    drain();
    do_op(4'd11, 32'h0001_0000, 32'h0001_0000, "mulu_2_32", lat);
    n_tests++;
    if (bus.res_hi !== 32'h1 || bus.res_lo !== 32'h0 || bus.zero !== 1'b1 || bus.co !== 1'b0) begin
      n_fail++;
      $display("FAIL mulu_2_32: res_hi=%h res_lo=%h zero=%0b co=%0b, required 1/0/1/0",
               bus.res_hi, bus.res_lo, bus.zero, bus.co);
    end
    drain();
    do_op(4'd11, 32'h1234_5678, 32'd2, "mulu_x2", lat);
    n_tests++;
    if (bus.res_hi !== 32'h0 || bus.res_lo !== 32'h2468_ACF0) begin
      n_fail++;
      $display("FAIL mulu_x2: res_hi=%h res_lo=%h, required 0/2468acf0", bus.res_hi, bus.res_lo);
    end
    drain();
  endtask

  task automatic test_divu();
    int lat;
    do_op(4'd12, 32'd100, 32'd7, "divu_100_7", lat);
    n_tests++;
    if (bus.res_lo !== 32'd14 || bus.res_hi !== 32'd2 || bus.dz !== 1'b0 || lat !== 33) begin
      n_fail++;
      $display("FAIL divu_100_7: q=%h r=%h dz=%0b lat=%0d, required e/2/0/33", bus.res_lo, bus.res_hi, bus.dz, lat);
    end
    drain();
    do_op(4'd12, 32'hFFFF_FFFF, 32'h10, "divu_big", lat);
    n_tests++;
    if (bus.res_lo !== 32'h0FFF_FFFF || bus.res_hi !== 32'hF || bus.dz !== 1'b0) begin
      n_fail++;
      $display("FAIL divu_big: q=%h r=%h dz=%0b, required 0fffffff/f/0", bus.res_lo, bus.res_hi, bus.dz);
    end
    drain();
    do_op(4'd12, 32'd5, 32'd9, "divu_small", lat);
    n_tests++;
    if (bus.res_lo !== 32'h0 || bus.res_hi !== 32'd5 || bus.zero !== 1'b1) begin
      n_fail++;
      $display("FAIL divu_small: q=%h r=%h zero=%0b, required 0/5/1", bus.res_lo, bus.res_hi, bus.zero);
    end
    drain();
    do_op(4'd12, 32'h1234, 32'h0, "divu_zero", lat);
    n_tests++;
    if (bus.res_lo !== 32'hFFFF_FFFF || bus.res_hi !== 32'h1234 || bus.dz !== 1'b1 || bus.zero !== 1'b0) begin
      n_fail++;
      $display("FAIL divu_zero: q=%h r=%h dz=%0b zero=%0b, required ffffffff/1234/1/0",
               bus.res_lo, bus.res_hi, bus.dz, bus.zero);
    end
    drain();
  endtask

  task automatic test_hold();
    int lat;
    bus.out_ready = 1'b0;
    do_op(4'd2, 32'd1, 32'd2, "hold_issue", lat);
    bus.in_valid = 1'b1;
    bus.op       = 4'd2;
    bus.a        = 32'd10;
    bus.b        = 32'd20;
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.res_lo !== 32'd3 || bus.res_hi !== '0 || bus.in_ready !== 1'b0 ||
          {bus.co, bus.zero, bus.overflow, bus.dz, bus.illegal} !== 5'b0) begin
        n_fail++;
        $display("FAIL hold[%0d]: out_valid=%0b res_lo=%h res_hi=%h in_ready=%0b flags=%b, required 1/3/0/0/00000",
                 i, bus.out_valid, bus.res_lo, bus.res_hi, bus.in_ready,
                 {bus.co, bus.zero, bus.overflow, bus.dz, bus.illegal});
      end
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_release: out_valid=%0b in_ready=%0b, required 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset_busy();
    int lat;
    bus.op       = 4'd11;
    bus.a        = 32'hFFFF_FFFF;
    bus.b        = 32'hFFFF_FFFF;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.res_lo !== '0 || bus.res_hi !== '0 ||
        {bus.co, bus.zero, bus.overflow, bus.dz, bus.illegal} !== 5'b0) begin
      n_fail++;
      $display("FAIL busy_reset: out_valid=%0b res_lo=%h res_hi=%h flags=%b, required 0/0/0/00000",
               bus.out_valid, bus.res_lo, bus.res_hi, {bus.co, bus.zero, bus.overflow, bus.dz, bus.illegal});
    end
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_reset_ready: in_ready=%0b, required 1", bus.in_ready);
    end
    do_op(4'd14, 32'h1111_2222, 32'h3333_4444, "illegal14", lat);
    n_tests++;
    if (bus.res_lo !== 32'hA5A5_A5A5 || bus.res_hi !== '0 || bus.illegal !== 1'b1 || lat !== 1 ||
        bus.zero !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal14: res_lo=%h res_hi=%h ill=%0b lat=%0d zero=%0b, required a5a5a5a5/0/1/1/0",
               bus.res_lo, bus.res_hi, bus.illegal, lat, bus.zero);
    end
    drain();
    do_op(4'd15, 32'h0, 32'h0, "illegal15", lat);
    n_tests++;
    if (bus.res_lo !== 32'hA5A5_A5A5 || bus.illegal !== 1'b1 || bus.co !== 1'b0 || bus.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal15: res_lo=%h ill=%0b co=%0b ovf=%0b, required a5a5a5a5/1/0/0",
               bus.res_lo, bus.illegal, bus.co, bus.overflow);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_add_sub_sra();
    test_single_cycle_table();
    test_mulu();
    test_divu();
    test_hold();
    test_reset_busy();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
